// File: rtl/mips_mem_pkg.sv
// Shared types for the instruction-fetch / data-memory arbiter: FSM states,
// requester IDs and the latched transaction record.
package mips_mem_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} arb_state_t;

   localparam logic REQ_IF = 1'b0;
   localparam logic REQ_DM = 1'b1;

   // Wide enough for MEM_LAT up to 7
   localparam int LAT_W = 3;

   typedef struct packed {
      logic [29:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic        id;
   } txn_t;

   function automatic txn_t make_txn(input logic [29:0] word_addr,
                                     input logic        we,
                                     input logic [3:0]  be,
                                     input logic [31:0] wdata,
                                     input logic        id);
      txn_t t;
      t.addr  = word_addr;
      t.we    = we;
      t.be    = be;
      t.wdata = wdata;
      t.id    = id;
      return t;
   endfunction

endpackage

// File: rtl/mem_arbiter_arb_pick.sv
// Two-requester winner selection, data over fetch. With ARB_STARVE_GUARD_EN
// a run of STARVE_MAX data grants against a waiting fetch forces one fetch grant.
module arb_pick
   import mips_mem_pkg::*;
`ifdef ARB_STARVE_GUARD_EN
#(
   parameter int STARVE_MAX = 4
)
`endif
(
`ifdef ARB_STARVE_GUARD_EN
   input  logic clk_in,
   input  logic reset,
`endif
   input  logic i_arb_en,
   input  logic i_if_req,
   input  logic i_dm_req,
   output logic o_pick_vld,
   output logic o_pick_id
);

`ifdef ARB_STARVE_GUARD_EN
   localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

   logic [CNT_W-1:0] r_starve_cnt;
   logic             w_force_if;

   assign w_force_if = i_if_req && (r_starve_cnt >= CNT_W'(STARVE_MAX));

   always_comb begin
      o_pick_vld = i_arb_en && (i_if_req || i_dm_req);
      o_pick_id  = (i_dm_req && !w_force_if) ? REQ_DM : REQ_IF;
   end

   // Saturates at STARVE_MAX; any fetch grant or an idle fetch port restarts the run
   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_starve_cnt <= '0;
      end else if (!i_if_req || (o_pick_vld && o_pick_id == REQ_IF)) begin
         r_starve_cnt <= '0;
      end else if (o_pick_vld && r_starve_cnt < CNT_W'(STARVE_MAX)) begin
         r_starve_cnt <= r_starve_cnt + 1'b1;
      end
   end
`else
   always_comb begin
      o_pick_vld = i_arb_en && (i_if_req || i_dm_req);
      o_pick_id  = i_dm_req ? REQ_DM : REQ_IF;
   end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter sharing one RAM port between fetch and data.
// Optional fetch starvation guard: define ARB_STARVE_GUARD_EN.
module mem_arbiter
   import mips_mem_pkg::*;
#(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
)
(
   input  logic        clk_in,
   input  logic        reset,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        dm_req,
   input  logic        dm_we,
   input  logic [3:0]  dm_be,
   input  logic [31:0] dm_addr,
   input  logic [31:0] dm_wdata,
   output logic        dm_gnt,
   output logic        dm_rvalid,
   output logic [31:0] dm_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [3:0]  mem_be,
   output logic [29:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata
);

   if (MEM_LAT < 1 || MEM_LAT > 7 || STARVE_MAX < 1) begin : g_bad_param
      $error("mem_arbiter: MEM_LAT must be 1..7 and STARVE_MAX at least 1");
   end

   arb_state_t       r_state;
   arb_state_t       w_state_next;
   txn_t             r_txn;
   logic [LAT_W-1:0] r_lat_cnt;
   logic [31:0]      r_if_rdata;
   logic [31:0]      r_dm_rdata;
   logic             w_arb_en;
   logic             w_pick_vld;
   logic             w_pick_id;
   logic             w_gnt_if;
   logic             w_gnt_dm;
   logic             w_done;
   logic             w_unused;

   // Byte-offset bits are dropped silently; there is no misalignment fault
   assign w_unused = &{1'b0, if_addr[1:0], dm_addr[1:0]};

   assign w_arb_en = (r_state == IDLE) && !reset;

   arb_pick
`ifdef ARB_STARVE_GUARD_EN
   #(
      .STARVE_MAX (STARVE_MAX)
   )
`endif
   u_pick (
`ifdef ARB_STARVE_GUARD_EN
      .clk_in     (clk_in),
      .reset      (reset),
`endif
      .i_arb_en   (w_arb_en),
      .i_if_req   (if_req),
      .i_dm_req   (dm_req),
      .o_pick_vld (w_pick_vld),
      .o_pick_id  (w_pick_id)
   );

   assign w_gnt_dm = w_pick_vld && (w_pick_id == REQ_DM);
   assign w_gnt_if = w_pick_vld && (w_pick_id == REQ_IF);

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_pick_vld) w_state_next = ACCESS;
         ACCESS:  w_state_next = (MEM_LAT == 1) ? DONE : WAIT;
         WAIT:    if (r_lat_cnt == LAT_W'(1)) w_state_next = DONE;
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_comb begin
      w_done    = (r_state == DONE) && !reset;
      if_gnt    = w_gnt_if;
      dm_gnt    = w_gnt_dm;
      if_rvalid = w_done && (r_txn.id == REQ_IF);
      dm_rvalid = w_done && (r_txn.id == REQ_DM);
      // RAM word is live in DONE; afterwards the registered copy holds it
      if_rdata  = if_rvalid ? mem_rdata : r_if_rdata;
      dm_rdata  = dm_rvalid ? (r_txn.we ? 32'h0 : mem_rdata) : r_dm_rdata;
      mem_en    = (r_state == ACCESS);
      mem_we    = mem_en && r_txn.we;
      mem_be    = mem_en ? r_txn.be    : 4'h0;
      mem_addr  = mem_en ? r_txn.addr  : 30'h0;
      mem_wdata = mem_en ? r_txn.wdata : 32'h0;
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         r_state    <= IDLE;
         r_txn      <= '0;
         r_lat_cnt  <= '0;
         r_if_rdata <= '0;
         r_dm_rdata <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_gnt_dm) begin
            r_txn <= make_txn(dm_addr[31:2], dm_we, dm_be, dm_wdata, REQ_DM);
         end else if (w_gnt_if) begin
            r_txn <= make_txn(if_addr[31:2], 1'b0, 4'hF, 32'h0, REQ_IF);
         end
         if (r_state == ACCESS) begin
            r_lat_cnt <= LAT_W'(MEM_LAT - 1);
         end else if (r_state == WAIT) begin
            r_lat_cnt <= r_lat_cnt - 1'b1;
         end
         if (if_rvalid) r_if_rdata <= if_rdata;
         if (dm_rvalid) r_dm_rdata <= dm_rdata;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1, one at MEM_LAT=3,
// each with a small latency-accurate RAM model.
module tb_mem_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        if_req[2];
   logic [31:0] if_addr[2];
   logic        if_gnt[2];
   logic        if_rvalid[2];
   logic [31:0] if_rdata[2];
   logic        dm_req[2];
   logic        dm_we[2];
   logic [3:0]  dm_be[2];
   logic [31:0] dm_addr[2];
   logic [31:0] dm_wdata[2];
   logic        dm_gnt[2];
   logic        dm_rvalid[2];
   logic [31:0] dm_rdata[2];
   logic        mem_en[2];
   logic        mem_we[2];
   logic [3:0]  mem_be[2];
   logic [29:0] mem_addr[2];
   logic [31:0] mem_wdata[2];
   logic [31:0] mem_rdata[2];

   logic [31:0] mem_arr[2][16];
   logic        wr_vld[2][16];
   logic [31:0] pipe[2][8];
   int          en_cnt[2] = '{0, 0};
   int          cyc = 0;
   int          total = 0;
   int          bad = 0;

   for (genvar gi = 0; gi < 2; gi++) begin : g_dut
      mem_arbiter #(.MEM_LAT((gi == 0) ? 1 : 3), .STARVE_MAX(4)) u_dut (
         .clk_in    (clk),
         .reset     (reset),
         .if_req    (if_req[gi]),
         .if_addr   (if_addr[gi]),
         .if_gnt    (if_gnt[gi]),
         .if_rvalid (if_rvalid[gi]),
         .if_rdata  (if_rdata[gi]),
         .dm_req    (dm_req[gi]),
         .dm_we     (dm_we[gi]),
         .dm_be     (dm_be[gi]),
         .dm_addr   (dm_addr[gi]),
         .dm_wdata  (dm_wdata[gi]),
         .dm_gnt    (dm_gnt[gi]),
         .dm_rvalid (dm_rvalid[gi]),
         .dm_rdata  (dm_rdata[gi]),
         .mem_en    (mem_en[gi]),
         .mem_we    (mem_we[gi]),
         .mem_be    (mem_be[gi]),
         .mem_addr  (mem_addr[gi]),
         .mem_wdata (mem_wdata[gi]),
         .mem_rdata (mem_rdata[gi])
      );
   end

   // Unwritten words read as 32'h2008_0004 + word index
   function automatic logic [31:0] rd_word(input int k, input logic [3:0] w);
      return wr_vld[k][w] ? mem_arr[k][w] : (32'h2008_0004 + {28'h0, w});
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = o;
      for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int k = 0; k < 2; k++) begin
         if (reset) for (int w = 0; w < 16; w++) wr_vld[k][w] <= 1'b0;
         if (mem_en[k]) en_cnt[k] <= en_cnt[k] + 1;
         if (mem_en[k] && mem_we[k]) begin
            mem_arr[k][mem_addr[k][3:0]] <= merge(rd_word(k, mem_addr[k][3:0]),
                                                  mem_wdata[k], mem_be[k]);
            wr_vld[k][mem_addr[k][3:0]]  <= 1'b1;
         end
         pipe[k][0] <= (mem_en[k] && !mem_we[k]) ? rd_word(k, mem_addr[k][3:0])
                                                 : 32'hBAD0_BAD0;
         for (int i = 1; i < 8; i++) pipe[k][i] <= pipe[k][i-1];
      end
   end

   assign mem_rdata[0] = pipe[0][0];
   assign mem_rdata[1] = pipe[1][2];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One complete transaction on instance k; fields are scrambled after grant
   task automatic run_txn(input int k, input bit dm, input bit we, input logic [3:0] be,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rd, input string tag);
      int lat;
      int n;
      int en0;
      lat = (k == 0) ? 1 : 3;
      if (dm) begin
         dm_req[k] = 1'b1; dm_we[k] = we; dm_be[k] = be;
         dm_addr[k] = addr; dm_wdata[k] = wdata;
      end else begin
         if_req[k] = 1'b1; if_addr[k] = addr;
      end
      #1;
      n = 0;
      while ((dm ? dm_gnt[k] : if_gnt[k]) !== 1'b1 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk({tag, ":gnt"}, dm ? dm_gnt[k] : if_gnt[k], 1);
      chk({tag, ":other_gnt"}, dm ? if_gnt[k] : dm_gnt[k], 0);
      @(negedge clk);
      if (dm) begin
         dm_req[k] = 1'b0; dm_we[k] = ~we; dm_be[k] = ~be;
         dm_addr[k] = ~addr; dm_wdata[k] = ~wdata;
      end else begin
         if_req[k] = 1'b0; if_addr[k] = ~addr;
      end
      #1;
      chk({tag, ":mem_en"}, mem_en[k], 1);
      chk({tag, ":mem_addr"}, mem_addr[k], addr[31:2]);
      chk({tag, ":mem_we_be"}, {mem_we[k], mem_be[k]}, dm ? {we, be} : 5'h0F);
      if (dm && we) chk({tag, ":mem_wdata"}, mem_wdata[k], wdata);
      en0 = en_cnt[k];
      n = 1;
      while ((dm ? dm_rvalid[k] : if_rvalid[k]) !== 1'b1 && n < 20) begin
         @(negedge clk); #1; n++;
      end
      chk({tag, ":latency"}, n, lat + 1);
      chk({tag, ":en_count"}, en_cnt[k] - en0, 1);
      chk({tag, ":rdata"}, dm ? dm_rdata[k] : if_rdata[k], exp_rd);
      chk({tag, ":other_rvalid"}, dm ? if_rvalid[k] : dm_rvalid[k], 0);
      @(negedge clk); #1;
      chk({tag, ":hold"}, dm ? {dm_rvalid[k], dm_rdata[k]} : {if_rvalid[k], if_rdata[k]},
          {1'b0, exp_rd});
      $display("txn %s inst=%0d %s addr=%h rdata=%h lat=%0d", tag, k,
               dm ? (we ? "store" : "load") : "fetch", addr, exp_rd, n);
   endtask

   task automatic pulse_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  last;
      int  rv_seen;
      int  n;
      logic exp_ids[6];

      reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         if_req[k] = 0; if_addr[k] = 0; dm_req[k] = 0; dm_we[k] = 0;
         dm_be[k] = 0; dm_addr[k] = 0; dm_wdata[k] = 0;
      end
      repeat (3) @(negedge clk); #1;
      chk("rst_ctl", {if_gnt[0], dm_gnt[0], if_rvalid[0], dm_rvalid[0],
                      mem_en[0], mem_we[0], mem_be[0]}, 0);
      chk("rst_addr_wdata", {mem_addr[0], mem_wdata[0]}, 0);
      chk("rst_rdata", {if_rdata[0], dm_rdata[0]}, 0);
      reset = 1'b0;
      @(negedge clk); #1;
      chk("idle_no_req", {if_gnt[0], dm_gnt[0], mem_en[0]}, 0);

      run_txn(0, 0, 0, 4'h0, 32'h0000_0004, 32'h0, 32'h2008_0005, "fetch_basic");

      if_req[0] = 1'b1; if_addr[0] = 32'h0000_0004;
      run_txn(0, 1, 0, 4'hF, 32'h0000_0010, 32'h0, 32'h2008_0008, "prio_load");
      chk("prio:if_after_done", if_gnt[0], 1);
      run_txn(0, 0, 0, 4'h0, 32'h0000_0004, 32'h0, 32'h2008_0005, "prio_fetch");

      run_txn(0, 1, 1, 4'b0011, 32'h0000_0020, 32'hDEAD_BEEF, 32'h0, "store");
      run_txn(0, 1, 0, 4'hF, 32'h0000_0020, 32'h0, 32'h2008_BEEF, "load_back");
      run_txn(0, 0, 0, 4'h0, 32'h0000_0023, 32'h0, 32'h2008_BEEF, "fetch_unaligned");

      // Both requesters held high: record grant order and spacing
      pulse_reset();
`ifdef ARB_STARVE_GUARD_EN
      exp_ids = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
`else
      exp_ids = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
      dm_req[0] = 1'b1; dm_we[0] = 1'b0; dm_be[0] = 4'hF; dm_addr[0] = 32'h0000_0010;
      if_req[0] = 1'b1; if_addr[0] = 32'h0000_0004;
      #1;
      last = 0;
      for (int g = 0; g < 6; g++) begin
         n = 0;
         while (!(if_gnt[0] || dm_gnt[0]) && n < 20) begin
            @(negedge clk); #1; n++;
         end
         chk($sformatf("starve%0d:any_gnt", g), if_gnt[0] | dm_gnt[0], 1);
         chk($sformatf("starve%0d:dm_won", g), dm_gnt[0], exp_ids[g]);
         if (g > 0) chk($sformatf("starve%0d:spacing", g), cyc - last, 3);
         last = cyc;
         $display("txn starve grant %0d -> %s", g, dm_gnt[0] ? "DM" : "IF");
         @(negedge clk); #1;
      end
      dm_req[0] = 1'b0; if_req[0] = 1'b0;
      repeat (4) @(negedge clk);
      pulse_reset();

      run_txn(1, 0, 0, 4'h0, 32'h0000_0008, 32'h0, 32'h2008_0006, "fetch_lat3");

      // Reset during WAIT abandons the fetch
      if_req[1] = 1'b1; if_addr[1] = 32'h0000_0008;
      #1;
      chk("rstmid:gnt", if_gnt[1], 1);
      @(negedge clk);
      if_req[1] = 1'b0;
      @(negedge clk); #1;
      chk("rstmid:in_wait", {mem_en[1], if_rvalid[1]}, 0);
      reset = 1'b1;
      @(negedge clk); #1;
      chk("rstmid:ctl", {if_gnt[1], dm_gnt[1], if_rvalid[1], dm_rvalid[1],
                         mem_en[1], mem_we[1], mem_be[1]}, 0);
      chk("rstmid:addr_wdata", {mem_addr[1], mem_wdata[1]}, 0);
      chk("rstmid:rdata", {if_rdata[1], dm_rdata[1]}, 0);
      reset = 1'b0;
      rv_seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk); #1;
         if (if_rvalid[1] || dm_rvalid[1] || mem_en[1]) rv_seen++;
      end
      chk("rstmid:no_rvalid", rv_seen, 0);
      run_txn(1, 0, 0, 4'h0, 32'h0000_000C, 32'h0, 32'h2008_0007, "fetch_after_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
